rom_scan_counter: RTL and testbench

- Sequencer and accumulator that sits directly upstream of the 8-bit lookup ROM and consumes its output.
- On a start request it sweeps the ROM address from 0 to LAST_ADDR, one address per clock.
- For each word it accumulates the sum of the returned data and the number of nonzero words.
- It then presents both results with a done flag, for the display/report stage.

---
 rtl/rom_scan_counter.sv | 162 ++++++++++++++++
 tb/tb_rom_scan_counter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : rom_scan_counter
// Purpose  : Sweeps a combinational lookup ROM from address 0 to LAST_ADDR,
//            one address per clock, and accumulates the saturating sum of
//            the returned words and the saturating count of nonzero words.
//            The results are presented with a done flag.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - sweep request, honoured in IDLE or DONE
//            address  - ROM address (registered, glitch-free)
//            data     - ROM data for the current address
//            busy     - sweep in progress
//            done     - results valid
//            sum      - saturating sum of swept words
//            hits     - saturating count of nonzero swept words
// Options  : ROM_PIPE_EN - registers the ROM data before accumulation and
//            adds a one-cycle FLUSH state for the final word.
// Revision : 1.0 - initial release
// ============================================================================
module rom_scan_counter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                COUNT_W   = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  data,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sum,
  output logic [COUNT_W-1:0] hits
);

  // One guard bit above the wider of the two addends so the saturation test
  // sees the true sum even when DATA_W exceeds COUNT_W.
  localparam int                 ACC_W     = ((COUNT_W > DATA_W) ? COUNT_W : DATA_W) + 1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef ROM_PIPE_EN
  localparam logic [1:0] S_FLUSH = 2'd3;
`endif

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               launch;
  logic               last_word;
  logic               accumulate;
  logic [DATA_W-1:0]  add_src;
  logic [ACC_W-1:0]   sum_wide;
  logic [COUNT_W-1:0] sum_sat;
  logic [COUNT_W-1:0] hits_sat;

  assign launch    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_word = (address == LAST_ADDR);

`ifdef ROM_PIPE_EN
  logic [DATA_W-1:0] data_q;

  // data_q is cleared on launch so the first SCAN cycle adds a harmless zero
  // while the word for address 0 is being captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (launch) begin
      data_q <= '0;
    end else if (state == S_SCAN) begin
      data_q <= data;
    end
  end

  assign add_src    = data_q;
  assign accumulate = (state == S_SCAN) || (state == S_FLUSH);
`else
  assign add_src    = data;
  assign accumulate = (state == S_SCAN);
`endif

  // Saturating accumulators: clamp at all-ones instead of wrapping.
  assign sum_wide = ACC_W'(sum) + ACC_W'(add_src);
  assign sum_sat  = (sum_wide > ACC_W'(COUNT_MAX)) ? COUNT_MAX : sum_wide[COUNT_W-1:0];
  assign hits_sat = ((add_src != '0) && (hits != COUNT_MAX)) ? hits + COUNT_W'(1) : hits;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (last_word) begin
`ifdef ROM_PIPE_EN
          state_next = S_FLUSH;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef ROM_PIPE_EN
      S_FLUSH: state_next = S_DONE;
`endif
      S_DONE: begin
        if (start) state_next = S_SCAN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SCAN:  busy = 1'b1;
`ifdef ROM_PIPE_EN
      S_FLUSH: busy = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address sequencer and accumulators; address holds at LAST_ADDR at the
  // end of a sweep so the ROM output stays stable for the report stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= '0;
      sum     <= '0;
      hits    <= '0;
    end else if (launch) begin
      address <= '0;
      sum     <= '0;
      hits    <= '0;
    end else begin
      if ((state == S_SCAN) && !last_word) begin
        address <= address + ADDR_W'(1);
      end
      if (accumulate) begin
        sum  <= sum_sat;
        hits <= hits_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_scan_counter
// Purpose  : Self-checking bench for rom_scan_counter. Four instances share
//            one clock, reset and start: full sweep, LAST_ADDR=0x33,
//            COUNT_W=2 and LAST_ADDR=0. A ROM array in the bench feeds each
//            instance. A behavioural model derives every output from the
//            number of edges since the sweep was launched and is compared on
//            every falling clock edge; literal expectations pin the model.
//            E0 below is the rising edge just before start is raised, so
//            start is first sampled at E0+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_scan_counter;

`ifdef ROM_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [7:0] rom [256];

  logic [7:0]  a0, a1, a2, a3;
  logic        b0, b1, b2, b3;
  logic        d0, d1, d2, d3;
  logic [15:0] s0, h0, s1, h1, s3, h3;
  logic [1:0]  s2, h2;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  // model state: act = launched since reset, j = edges since launch
  int         act [NI];
  int         j   [NI];
  logic [7:0] snap [NI][256];

  always #5 clk = ~clk;

  rom_scan_counter u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .address(a0), .data(rom[a0]),
    .busy(b0), .done(d0), .sum(s0), .hits(h0));

  rom_scan_counter #(.LAST_ADDR(8'h33)) u_part (
    .clk(clk), .rst_n(rst_n), .start(start), .address(a1), .data(rom[a1]),
    .busy(b1), .done(d1), .sum(s1), .hits(h1));

  rom_scan_counter #(.COUNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .address(a2), .data(rom[a2]),
    .busy(b2), .done(d2), .sum(s2), .hits(h2));

  rom_scan_counter #(.LAST_ADDR(8'h00)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .address(a3), .data(rom[a3]),
    .busy(b3), .done(d3), .sum(s3), .hits(h3));

  function automatic int last_of(input int i);
    case (i)
      1:       return 51;
      3:       return 0;
      default: return 255;
    endcase
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  // edges from launch until done
  function automatic int ntot(input int i);
    return last_of(i) + 1 + PIPE;
  endfunction

  // Behavioural model
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        act[i] = 0;
        j[i]   = 0;
      end else if (start && (act[i] == 0 || j[i] == ntot(i))) begin
        act[i] = 1;
        j[i]   = 0;
        for (int k = 0; k < 256; k++) snap[i][k] = rom[k];
      end else if (act[i] != 0 && j[i] < ntot(i)) begin
        j[i] = j[i] + 1;
      end
    end
  end

  task automatic check_inst(input int i, input int ga, input int gb, input int gd,
                            input int gs, input int gh);
    int ea, eb, ed, es, eh, w;
    ea = 0; eb = 0; ed = 0; es = 0; eh = 0;
    if (act[i] != 0) begin
      ea = (j[i] < last_of(i)) ? j[i] : last_of(i);
      eb = (j[i] < ntot(i)) ? 1 : 0;
      ed = (j[i] == ntot(i)) ? 1 : 0;
      w  = j[i] - PIPE;
      if (w < 0) w = 0;
      if (w > last_of(i) + 1) w = last_of(i) + 1;
      for (int k = 0; k < w; k++) begin
        es += int'(snap[i][k]);
        if (snap[i][k] != 8'd0) eh++;
      end
      if (es > max_of(i)) es = max_of(i);
      if (eh > max_of(i)) eh = max_of(i);
    end
    n_chk++;
    if (ga != ea || gb != eb || gd != ed || gs != es || gh != eh) begin
      n_err++;
      $display("FAIL model inst%0d t=%0t: addr/busy/done/sum/hits got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
               i, $time, ga, gb, gd, gs, gh, ea, eb, ed, es, eh);
    end
  endtask

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, int'(a0), int'(b0), int'(d0), int'(s0), int'(h0));
      check_inst(1, int'(a1), int'(b1), int'(d1), int'(s1), int'(h1));
      check_inst(2, int'(a2), int'(b2), int'(d2), int'(s2), int'(h2));
      check_inst(3, int'(a3), int'(b3), int'(d3), int'(s3), int'(h3));
    end
  end

  task automatic pin(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic pin_final(input string tag, input int es0, input int eh0, input int es1,
                           input int eh1, input int es2, input int eh2, input int es3,
                           input int eh3);
    pin({tag, " def sum"}, int'(s0), es0);
    pin({tag, " def hits"}, int'(h0), eh0);
    pin({tag, " def addr"}, int'(a0), 255);
    pin({tag, " part sum"}, int'(s1), es1);
    pin({tag, " part hits"}, int'(h1), eh1);
    pin({tag, " sat sum"}, int'(s2), es2);
    pin({tag, " sat hits"}, int'(h2), eh2);
    pin({tag, " zero sum"}, int'(s3), es3);
    pin({tag, " zero hits"}, int'(h3), eh3);
  endtask

  // Launch a sweep with a start pulse of 'pulse' cycles; optionally pulse start
  // again when the full-sweep instance reaches mid_addr. Checks done latency
  // and the clearing one edge after launch.
  task automatic run_sweep(input int pulse, input int mid_addr, input bit pin_lat);
    int k;
    int lat [NI];
    bit all_done;
    for (int i = 0; i < NI; i++) lat[i] = 0;
    @(posedge clk);
    #1 start = 1'b1;
    k = 0;
    all_done = 1'b0;
    while (!all_done && k < 800) begin
      @(posedge clk);
      k++;
      #1;
      start = (k < pulse) || (mid_addr >= 0 && b0 && int'(a0) == mid_addr);
      if (k == 1) begin
        pin("launch clears sum", int'(s0), 0);
        pin("launch clears hits", int'(h0), 0);
        pin("launch busy/done", int'({b0, d0}), 2);
      end
      if (d0 && lat[0] == 0) lat[0] = k;
      if (d1 && lat[1] == 0) lat[1] = k;
      if (d2 && lat[2] == 0) lat[2] = k;
      if (d3 && lat[3] == 0) lat[3] = k;
      all_done = d0 && d1 && d2 && d3 && !start && k > pulse;
    end
    if (!all_done) pin("sweep completion within budget", 0, 1);
    if (pin_lat) begin
      pin("latency def", lat[0], 257 + PIPE);
      pin("latency part", lat[1], 53 + PIPE);
      pin("latency sat", lat[2], 257 + PIPE);
      pin("latency zero", lat[3], 2 + PIPE);
    end
  endtask

  // Start a sweep, then assert reset between edges once address reaches addr.
  task automatic reset_mid(input int addr);
    int k;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (!(b0 && int'(a0) == addr) && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 600) pin("reach reset address within budget", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    pin("async rst addr", int'(a0), 0);
    pin("async rst busy/done", int'({b0, d0}), 0);
    pin("async rst sum/hits", int'(s0) + int'(h0), 0);
    pin("async rst part done", int'(d1), 0);
    pin("async rst part sum", int'(s1), 0);
    #4 rst_n = 1'b1;
  endtask

  task automatic load_shipped();
    for (int k = 0; k < 256; k++) rom[k] = 8'h00;
    for (int k = 1; k <= 7; k++) rom[k * 17] = 8'h01;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dens;
    for (int i = 0; i < NI; i++) begin
      act[i] = 0;
      j[i]   = 0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    load_shipped();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    pin("reset addr", int'(a0), 0);
    pin("reset busy", int'(b0), 0);
    pin("reset done", int'(d0), 0);
    pin("reset sum", int'(s0), 0);
    pin("reset hits", int'(h0), 0);
    #2 rst_n = 1'b1;

    // Shipped ROM: plain sweep, then mid-sweep start (also restarts from DONE)
    run_sweep(1, -1, 1'b1);
    pin_final("shipped", 7, 7, 3, 3, 3, 3, 0, 0);
    run_sweep(1, 64, 1'b1);
    pin_final("midstart", 7, 7, 3, 3, 3, 3, 0, 0);

    // Reset at address 0x50, then a normal sweep
    reset_mid(80);
    repeat (2) @(posedge clk);
    run_sweep(1, -1, 1'b1);
    pin_final("after reset", 7, 7, 3, 3, 3, 3, 0, 0);

    // Stub ROM returning 0xFF everywhere: saturation of the narrow instance
    for (int k = 0; k < 256; k++) rom[k] = 8'hFF;
    run_sweep(1, -1, 1'b1);
    pin_final("allFF", 65280, 256, 13260, 52, 3, 3, 255, 1);

    // Randomized sweeps checked by the model every cycle
    for (int it = 0; it < 12; it++) begin
      dens = $urandom_range(0, 4);
      for (int k = 0; k < 256; k++)
        rom[k] = ($urandom_range(0, 3) < dens) ? 8'($urandom_range(1, 255)) : 8'h00;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) begin
        reset_mid($urandom_range(1, 250));
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      run_sweep($urandom_range(1, 3),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 250) : -1, 1'b1);
    end

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
